prbs_rx_checker: RTL and testbench

- Fabric-side PRBS checker and bit-error accumulator for one front-panel BERT receive lane.
- Consumes the 32-bit parallel word stream and the GTX hardware PRBS error flag in the lane RX user-clock domain.
- Provides lock detection, true bit-error counts (not the multiplied self-sync count) and an atomic snapshot for the management side to read BER.

---
 rtl/bert_pkg.sv | 59 +++++
 rtl/prbs_rx_checker_if.sv | 10 +
 rtl/prbs_parallel_predict.sv | 36 +++
 rtl/prbs_rx_checker.sv | 217 +++++++++++++++++++++
 tb/tb_prbs_rx_checker.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bert_pkg.sv
// rtl/bert_pkg.sv - shared types, tap constants and helpers for the BERT lane checker
package bert_pkg;

  localparam int WORD_W      = 32;
  localparam int HIST_W      = 31;
  localparam int CNT_W       = 48;
  localparam int HW_ERR_W    = 32;
  localparam int LOCK_LOST_W = 16;

  typedef enum logic [2:0] {
    PRBS_OFF = 3'b000,
    PRBS_7   = 3'b001,
    PRBS_15  = 3'b010,
    PRBS_23  = 3'b011,
    PRBS_31  = 3'b100
  } prbs_sel_t;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SEARCH   = 2'd1,
    ST_LOCKED   = 2'd2
  } checker_state_t;

  // s[n] = s[n-N] ^ s[n-M]
  localparam logic [5:0] TAP_N_7  = 6'd7,  TAP_M_7  = 6'd6;
  localparam logic [5:0] TAP_N_15 = 6'd15, TAP_M_15 = 6'd14;
  localparam logic [5:0] TAP_N_23 = 6'd23, TAP_M_23 = 6'd18;
  localparam logic [5:0] TAP_N_31 = 6'd31, TAP_M_31 = 6'd28;

  function automatic logic sel_is_valid(input logic [2:0] s);
    return s inside {PRBS_7, PRBS_15, PRBS_23, PRBS_31};
  endfunction

  function automatic logic [5:0] tap_n(input logic [2:0] s);
    case (s)
      PRBS_15: return TAP_N_15;
      PRBS_23: return TAP_N_23;
      PRBS_31: return TAP_N_31;
      default: return TAP_N_7;
    endcase
  endfunction

  function automatic logic [5:0] tap_m(input logic [2:0] s);
    case (s)
      PRBS_15: return TAP_M_15;
      PRBS_23: return TAP_M_23;
      PRBS_31: return TAP_M_31;
      default: return TAP_M_7;
    endcase
  endfunction

  function automatic logic [5:0] popcount32(input logic [WORD_W-1:0] w);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < WORD_W; i++) c = c + {5'b0, w[i]};
    return c;
  endfunction

endpackage

// File: rtl/prbs_rx_checker_if.sv
// rtl/prbs_rx_checker_if.sv - receive lane bundle from the transceiver into the checker
interface prbs_rx_checker_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_invert;
  logic             hw_err_in;

  modport master (output rx_data, rx_valid, rx_invert, hw_err_in);
  modport slave  (input  rx_data, rx_valid, rx_invert, hw_err_in);
endinterface

// File: rtl/prbs_parallel_predict.sv
// rtl/prbs_parallel_predict.sv - combinational 32-bit PRBS prediction from a 31-bit history
// With self_sync set, later bits are predicted from the received bits instead of predicted ones.
module prbs_parallel_predict
  import bert_pkg::*;
(
  input  logic [2:0]        prbs_sel,
  input  logic [HIST_W-1:0] hist_in,
  input  logic [WORD_W-1:0] rx_word,
  input  logic              self_sync,
  output logic [WORD_W-1:0] exp_word,
  output logic [HIST_W-1:0] hist_out
);

  always_comb begin
    logic [62:0] seq;
    logic [5:0]  n;
    logic [5:0]  m;
    logic [5:0]  idx_n;
    logic [5:0]  idx_m;
    seq      = '0;
    exp_word = '0;
    hist_out = '0;
    n        = tap_n(prbs_sel);
    m        = tap_m(prbs_sel);
    // hist_in[0] is the most recent bit; seq is laid out oldest-first
    for (int k = 0; k < HIST_W; k++) seq[30-k] = hist_in[k];
    for (int j = 0; j < WORD_W; j++) begin
      idx_n       = 6'(31 + j) - n;
      idx_m       = 6'(31 + j) - m;
      exp_word[j] = seq[idx_n] ^ seq[idx_m];
      seq[31+j]   = self_sync ? rx_word[j] : exp_word[j];
    end
    for (int k = 0; k < HIST_W; k++) hist_out[k] = seq[62-k];
  end

endmodule

// File: rtl/prbs_rx_checker.sv
// rtl/prbs_rx_checker.sv - PRBS lock FSM, true bit-error accumulation and atomic snapshot
module prbs_rx_checker
  import bert_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int COUNT_WIDTH  = 48,
  parameter int LOCK_WORDS   = 32,
  parameter int BAD_BITS     = 8,
  parameter int UNLOCK_WORDS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  prbs_rx_checker_if.slave           rx,
  input  logic [2:0]                 prbs_sel,
  input  logic                       clear,
  input  logic                       snap_req,
  output logic                       snap_ack,
  output logic                       locked,
  output logic [COUNT_WIDTH-1:0]     snap_bits,
  output logic [COUNT_WIDTH-1:0]     snap_errs,
  output logic [HW_ERR_W-1:0]        snap_hw_errs,
  output logic [LOCK_LOST_W-1:0]     snap_lock_lost
);

  localparam int CLEAN_W = $clog2(LOCK_WORDS + 1);
  localparam int BAD_W   = $clog2(UNLOCK_WORDS + 1);
  localparam int CW1     = COUNT_WIDTH + 1;

  checker_state_t state_q, state_d;
  logic [WIDTH-1:0]       cap_data_q, cap_data_d;
  logic                   cap_valid_q, cap_valid_d;
  logic [2:0]             sel_q, sel_d;
  logic                   primed_q, primed_d;
  logic [CLEAN_W-1:0]     clean_q, clean_d;
  logic [BAD_W-1:0]       bad_q, bad_d;
  logic [HIST_W-1:0]      hist_q, hist_d;
  logic [HIST_W-1:0]      lfsr_q, lfsr_d;
  logic [5:0]             pc_q, pc_d;
  logic                   cnt_v_q, cnt_v_d;
  logic                   locked_q, locked_d;
  logic [COUNT_WIDTH-1:0] bits_q, bits_d, errs_q, errs_d;
  logic [HW_ERR_W-1:0]    hw_q, hw_d;
  logic [LOCK_LOST_W-1:0] lost_q, lost_d;
  logic                   snap_ack_q, snap_ack_d;
  logic [COUNT_WIDTH-1:0] snap_bits_q, snap_bits_d, snap_errs_q, snap_errs_d;
  logic [HW_ERR_W-1:0]    snap_hw_q, snap_hw_d;
  logic [LOCK_LOST_W-1:0] snap_lost_q, snap_lost_d;

  logic [WORD_W-1:0] ss_exp, lf_exp, mask;
  logic [HIST_W-1:0] ss_hist, lf_hist;
  logic [5:0]        pc;
  logic              lost_inc;
  logic [CW1-1:0]    bits_sum, errs_sum;
  logic [HW_ERR_W:0] hw_sum;
  logic [LOCK_LOST_W:0] lost_sum;

  prbs_parallel_predict u_ss (
    .prbs_sel (sel_q),
    .hist_in  (hist_q),
    .rx_word  (cap_data_q),
    .self_sync(1'b1),
    .exp_word (ss_exp),
    .hist_out (ss_hist)
  );

  prbs_parallel_predict u_lf (
    .prbs_sel (sel_q),
    .hist_in  (lfsr_q),
    .rx_word  (cap_data_q),
    .self_sync(1'b0),
    .exp_word (lf_exp),
    .hist_out (lf_hist)
  );

  always_comb begin
    cap_data_d  = rx.rx_data ^ {WIDTH{rx.rx_invert}};
    cap_valid_d = rx.rx_valid;
    state_d     = state_q;
    sel_d       = prbs_sel;
    primed_d    = primed_q;
    clean_d     = clean_q;
    bad_d       = bad_q;
    hist_d      = hist_q;
    lfsr_d      = lfsr_q;
    pc_d        = '0;
    cnt_v_d     = 1'b0;
    lost_inc    = 1'b0;
    mask        = ((state_q == ST_LOCKED) ? lf_exp : ss_exp) ^ cap_data_q;
    pc          = popcount32(mask);

    // A mode change discards the word in flight and forces a fresh prime.
    if (prbs_sel != sel_q || !sel_is_valid(prbs_sel)) begin
      state_d  = sel_is_valid(prbs_sel) ? ST_SEARCH : ST_DISABLED;
      primed_d = 1'b0;
      clean_d  = '0;
      bad_d    = '0;
    end else if (cap_valid_q) begin
      hist_d = ss_hist;
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if (state_q == ST_SEARCH) begin
        lfsr_d = ss_hist;
        if (pc == 6'd0) begin
          if (clean_q == CLEAN_W'(LOCK_WORDS - 1)) begin
            state_d = ST_LOCKED;
            clean_d = '0;
            bad_d   = '0;
          end else begin
            clean_d = clean_q + 1'b1;
          end
        end else begin
          clean_d = '0;
        end
      end else if (state_q == ST_LOCKED) begin
        lfsr_d  = lf_hist;
        pc_d    = pc;
        cnt_v_d = 1'b1;
        if (pc >= 6'(BAD_BITS)) begin
          if (bad_q == BAD_W'(UNLOCK_WORDS - 1)) begin
            state_d  = ST_SEARCH;
            primed_d = 1'b0;
            clean_d  = '0;
            bad_d    = '0;
            lost_inc = 1'b1;
          end else begin
            bad_d = bad_q + 1'b1;
          end
        end else begin
          bad_d = '0;
        end
      end
    end
    locked_d = (state_d == ST_LOCKED);

    bits_sum = {1'b0, bits_q} + CW1'(WORD_W);
    errs_sum = {1'b0, errs_q} + CW1'(pc_q);
    hw_sum   = {1'b0, hw_q} + (HW_ERR_W + 1)'(rx.hw_err_in);
    lost_sum = {1'b0, lost_q} + (LOCK_LOST_W + 1)'(lost_inc);
    bits_d   = bits_q;
    errs_d   = errs_q;
    if (cnt_v_q) begin
      bits_d = bits_sum[COUNT_WIDTH] ? '1 : bits_sum[COUNT_WIDTH-1:0];
      errs_d = errs_sum[COUNT_WIDTH] ? '1 : errs_sum[COUNT_WIDTH-1:0];
    end
    hw_d   = hw_sum[HW_ERR_W] ? '1 : hw_sum[HW_ERR_W-1:0];
    lost_d = lost_sum[LOCK_LOST_W] ? '1 : lost_sum[LOCK_LOST_W-1:0];
    if (clear) begin
      bits_d = '0;
      errs_d = '0;
      hw_d   = '0;
      lost_d = '0;
    end

    // Snapshot samples the pre-clear register values.
    snap_ack_d  = snap_req;
    snap_bits_d = snap_req ? bits_q : snap_bits_q;
    snap_errs_d = snap_req ? errs_q : snap_errs_q;
    snap_hw_d   = snap_req ? hw_q   : snap_hw_q;
    snap_lost_d = snap_req ? lost_q : snap_lost_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_DISABLED;
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
      sel_q       <= 3'b000;
      primed_q    <= 1'b0;
      clean_q     <= '0;
      bad_q       <= '0;
      hist_q      <= '0;
      lfsr_q      <= '0;
      pc_q        <= '0;
      cnt_v_q     <= 1'b0;
      locked_q    <= 1'b0;
      bits_q      <= '0;
      errs_q      <= '0;
      hw_q        <= '0;
      lost_q      <= '0;
      snap_ack_q  <= 1'b0;
      snap_bits_q <= '0;
      snap_errs_q <= '0;
      snap_hw_q   <= '0;
      snap_lost_q <= '0;
    end else begin
      state_q     <= state_d;
      cap_data_q  <= cap_data_d;
      cap_valid_q <= cap_valid_d;
      sel_q       <= sel_d;
      primed_q    <= primed_d;
      clean_q     <= clean_d;
      bad_q       <= bad_d;
      hist_q      <= hist_d;
      lfsr_q      <= lfsr_d;
      pc_q        <= pc_d;
      cnt_v_q     <= cnt_v_d;
      locked_q    <= locked_d;
      bits_q      <= bits_d;
      errs_q      <= errs_d;
      hw_q        <= hw_d;
      lost_q      <= lost_d;
      snap_ack_q  <= snap_ack_d;
      snap_bits_q <= snap_bits_d;
      snap_errs_q <= snap_errs_d;
      snap_hw_q   <= snap_hw_d;
      snap_lost_q <= snap_lost_d;
    end
  end

  assign snap_ack       = snap_ack_q;
  assign locked         = locked_q;
  assign snap_bits      = snap_bits_q;
  assign snap_errs      = snap_errs_q;
  assign snap_hw_errs   = snap_hw_q;
  assign snap_lock_lost = snap_lost_q;

endmodule

// File: tb/tb_prbs_rx_checker.sv
// tb/tb_prbs_rx_checker.sv - directed self-checking bench for the PRBS lane checker
module tb_prbs_rx_checker;

  logic        clk;
  logic        rst_n;
  logic [2:0]  prbs_sel;
  logic        clear;
  logic        snap_req;
  logic        snap_ack, locked;
  logic [47:0] snap_bits, snap_errs;
  logic [31:0] snap_hw_errs;
  logic [15:0] snap_lock_lost;
  logic        s_snap_ack, s_locked;
  logic [7:0]  s_snap_bits, s_snap_errs;
  logic [31:0] s_snap_hw_errs;
  logic [15:0] s_snap_lock_lost;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] g;
  int gn, gm;

  prbs_rx_checker_if #(.WIDTH(32)) rx_if ();

  prbs_rx_checker #(.COUNT_WIDTH(48)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_if), .prbs_sel(prbs_sel), .clear(clear),
    .snap_req(snap_req), .snap_ack(snap_ack), .locked(locked), .snap_bits(snap_bits),
    .snap_errs(snap_errs), .snap_hw_errs(snap_hw_errs), .snap_lock_lost(snap_lock_lost)
  );

  prbs_rx_checker #(.COUNT_WIDTH(8)) u_small (
    .clk(clk), .rst_n(rst_n), .rx(rx_if), .prbs_sel(prbs_sel), .clear(clear),
    .snap_req(snap_req), .snap_ack(s_snap_ack), .locked(s_locked), .snap_bits(s_snap_bits),
    .snap_errs(s_snap_errs), .snap_hw_errs(s_snap_hw_errs), .snap_lock_lost(s_snap_lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic gen_seed(input int n, input int m);
    g = '1; gn = n; gm = m;
  endtask

  // Serial reference generator: one bit at a time, g[0] is the newest bit.
  task automatic gen_word(output logic [31:0] w);
    logic b;
    for (int j = 0; j < 32; j++) begin
      b = g[gn-1] ^ g[gm-1];
      g = {g[62:0], b};
      w[j] = b;
    end
  endtask

  task automatic idle(input int n);
    rx_if.rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] w);
    rx_if.rx_data = w; rx_if.rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic send_clean(input int n);
    logic [31:0] w;
    repeat (n) begin gen_word(w); send(w); end
  endtask

  task automatic set_sel(input logic [2:0] s);
    prbs_sel = s;
    idle(2);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic snap();
    snap_req = 1'b1; @(posedge clk); #1; snap_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %0b want 0", locked); end
    n_cmp++; if (snap_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %0b want 0", snap_ack); end
    n_cmp++; if (snap_bits !== 48'd0) begin n_bad++; $display("FAIL reset_bits got %0d want 0", snap_bits); end
    n_cmp++; if (snap_errs !== 48'd0) begin n_bad++; $display("FAIL reset_errs got %0d want 0", snap_errs); end
    n_cmp++; if (snap_hw_errs !== 32'd0) begin n_bad++; $display("FAIL reset_hw got %0d want 0", snap_hw_errs); end
    n_cmp++; if (snap_lock_lost !== 16'd0) begin n_bad++; $display("FAIL reset_lost got %0d want 0", snap_lock_lost); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_prbs15_lock();
    set_sel(3'b010);
    gen_seed(15, 14);
    send_clean(32); idle(2);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL p15_early_lock got %0b want 0", locked); end
    send_clean(1); idle(2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL p15_lock got %0b want 1", locked); end
    pulse_clear();
    send_clean(100); idle(4);
    snap();
    n_cmp++; if (snap_ack !== 1'b1) begin n_bad++; $display("FAIL p15_ack got %0b want 1", snap_ack); end
    n_cmp++; if (snap_bits !== 48'd3200) begin n_bad++; $display("FAIL p15_bits got %0d want 3200", snap_bits); end
    n_cmp++; if (snap_errs !== 48'd0) begin n_bad++; $display("FAIL p15_errs got %0d want 0", snap_errs); end
    idle(1);
    n_cmp++; if (snap_ack !== 1'b0) begin n_bad++; $display("FAIL p15_ack_pulse got %0b want 0", snap_ack); end
  endtask

  task automatic test_single_bit_error();
    logic [31:0] w;
    set_sel(3'b100);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL p31_sel_change got %0b want 0", locked); end
    gen_seed(31, 28);
    send_clean(33); idle(2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL p31_lock got %0b want 1", locked); end
    pulse_clear();
    for (int i = 0; i < 20; i++) begin
      gen_word(w);
      send((i == 9) ? (w ^ 32'h0000_0020) : w);
    end
    idle(4);
    snap();
    n_cmp++; if (snap_errs !== 48'd1) begin n_bad++; $display("FAIL p31_errs got %0d want 1", snap_errs); end
    n_cmp++; if (snap_bits !== 48'd640) begin n_bad++; $display("FAIL p31_bits got %0d want 640", snap_bits); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL p31_hold got %0b want 1", locked); end
    n_cmp++; if (snap_lock_lost !== 16'd0) begin n_bad++; $display("FAIL p31_lost got %0d want 0", snap_lock_lost); end
  endtask

  task automatic test_invert();
    logic [31:0] w;
    set_sel(3'b001);
    gen_seed(7, 6);
    pulse_clear();
    rx_if.rx_invert = 1'b0;
    repeat (50) begin gen_word(w); send(~w); end
    idle(4);
    snap();
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL inv_nolock got %0b want 0", locked); end
    n_cmp++; if (snap_bits !== 48'd0) begin n_bad++; $display("FAIL inv_bits got %0d want 0", snap_bits); end
    n_cmp++; if (snap_errs !== 48'd0) begin n_bad++; $display("FAIL inv_errs got %0d want 0", snap_errs); end
    rx_if.rx_invert = 1'b1;
    repeat (33) begin gen_word(w); send(~w); end
    idle(2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL inv_lock got %0b want 1", locked); end
    rx_if.rx_invert = 1'b0;
  endtask

  task automatic test_unlock();
    logic [31:0] w;
    int exp_errs, nsent, run;
    set_sel(3'b011);
    gen_seed(23, 18);
    send_clean(33); idle(2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL p23_lock got %0b want 1", locked); end
    pulse_clear();
    exp_errs = 0; nsent = 0; run = 0;
    while (run < 16 && nsent < 64) begin
      gen_word(w);
      exp_errs += $countones(w);
      run = ($countones(w) >= 8) ? run + 1 : 0;
      nsent++;
      send(32'h0);
    end
    idle(4);
    snap();
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL p23_unlock got %0b want 0", locked); end
    n_cmp++; if (snap_lock_lost !== 16'd1) begin n_bad++; $display("FAIL p23_lost got %0d want 1", snap_lock_lost); end
    n_cmp++; if (snap_errs !== 48'(exp_errs)) begin n_bad++; $display("FAIL p23_errs got %0d want %0d", snap_errs, exp_errs); end
    n_cmp++; if (snap_bits !== 48'(32 * nsent)) begin n_bad++; $display("FAIL p23_bits got %0d want %0d", snap_bits, 32 * nsent); end
    send_clean(33); idle(2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL p23_relock got %0b want 1", locked); end
  endtask

  task automatic test_valid_gaps();
    set_sel(3'b010);
    gen_seed(15, 14);
    send_clean(33); idle(2);
    pulse_clear();
    repeat (40) begin send_clean(1); idle(1); end
    idle(4);
    snap();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL gap_lock got %0b want 1", locked); end
    n_cmp++; if (snap_bits !== 48'd1280) begin n_bad++; $display("FAIL gap_bits got %0d want 1280", snap_bits); end
    n_cmp++; if (snap_errs !== 48'd0) begin n_bad++; $display("FAIL gap_errs got %0d want 0", snap_errs); end
    set_sel(3'b100);
    snap();
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL gap_sel_search got %0b want 0", locked); end
    n_cmp++; if (snap_bits !== 48'd1280) begin n_bad++; $display("FAIL gap_sel_kept got %0d want 1280", snap_bits); end
  endtask

  task automatic test_saturation();
    logic [31:0] w;
    gen_seed(31, 28);
    send_clean(33); idle(2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL sat_lock got %0b want 1", locked); end
    pulse_clear();
    repeat (70) begin gen_word(w); send(w ^ 32'h0000_000F); end
    idle(4);
    snap();
    n_cmp++; if (s_snap_errs !== 8'd255) begin n_bad++; $display("FAIL sat_small_errs got %0d want 255", s_snap_errs); end
    n_cmp++; if (s_snap_bits !== 8'd255) begin n_bad++; $display("FAIL sat_small_bits got %0d want 255", s_snap_bits); end
    n_cmp++; if (snap_errs !== 48'd280) begin n_bad++; $display("FAIL sat_main_errs got %0d want 280", snap_errs); end
    n_cmp++; if (snap_bits !== 48'd2240) begin n_bad++; $display("FAIL sat_main_bits got %0d want 2240", snap_bits); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL sat_hold got %0b want 1", locked); end
  endtask

  task automatic test_clear_snap();
    logic a1, a2, a3;
    clear = 1'b1; snap_req = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; snap_req = 1'b0;
    n_cmp++; if (snap_ack !== 1'b1) begin n_bad++; $display("FAIL cs_ack got %0b want 1", snap_ack); end
    n_cmp++; if (snap_errs !== 48'd280) begin n_bad++; $display("FAIL cs_pre_errs got %0d want 280", snap_errs); end
    n_cmp++; if (s_snap_errs !== 8'd255) begin n_bad++; $display("FAIL cs_pre_small got %0d want 255", s_snap_errs); end
    idle(1);
    snap();
    n_cmp++; if (snap_errs !== 48'd0) begin n_bad++; $display("FAIL cs_post_errs got %0d want 0", snap_errs); end
    n_cmp++; if (snap_bits !== 48'd0) begin n_bad++; $display("FAIL cs_post_bits got %0d want 0", snap_bits); end
    idle(1);
    snap_req = 1'b1;
    @(posedge clk); #1; a1 = snap_ack;
    @(posedge clk); #1; a2 = snap_ack;
    snap_req = 1'b0;
    @(posedge clk); #1; a3 = snap_ack;
    n_cmp++; if ({a1, a2, a3} !== 3'b110) begin n_bad++; $display("FAIL b2b_acks got %b want 110", {a1, a2, a3}); end
  endtask

  task automatic test_hw_err();
    pulse_clear();
    rx_if.hw_err_in = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rx_if.hw_err_in = 1'b0;
    snap();
    n_cmp++; if (snap_hw_errs !== 32'd5) begin n_bad++; $display("FAIL hw_count got %0d want 5", snap_hw_errs); end
    rx_if.hw_err_in = 1'b1;
    pulse_clear();
    rx_if.hw_err_in = 1'b0;
    snap();
    n_cmp++; if (snap_hw_errs !== 32'd0) begin n_bad++; $display("FAIL hw_clear_wins got %0d want 0", snap_hw_errs); end
  endtask

  initial begin
    rst_n = 1'b0;
    prbs_sel = 3'b000;
    clear = 1'b0;
    snap_req = 1'b0;
    rx_if.rx_data = '0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_invert = 1'b0;
    rx_if.hw_err_in = 1'b0;
    test_reset();
    test_prbs15_lock();
    test_single_bit_error();
    test_invert();
    test_unlock();
    test_valid_gaps();
    test_saturation();
    test_clear_snap();
    test_hw_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
